// File: rtl/gpr_transfer_ctrl_pkg.sv
// Shared constants, op codes, state encoding and control-line bundle for gpr_transfer_ctrl.
// Optional swap support is selected by the GPR_TRANSFER_SWAP_EN macro.
package gpr_ctrl_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned TMP_W    = 2;
  localparam int unsigned STATE_W  = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 2'b00,
    OP_MOV  = 2'b01,
    OP_LDI  = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_MOV_RD   = 4'd1;
  localparam logic [3:0] ST_MOV_WR   = 4'd2;
  localparam logic [3:0] ST_LDI_WR   = 4'd3;
  localparam logic [3:0] ST_SWP_A    = 4'd4;
  localparam logic [3:0] ST_SWP_B    = 4'd5;
  localparam logic [3:0] ST_SWP_C    = 4'd6;
  localparam logic [3:0] ST_SWP_D    = 4'd7;
  localparam logic [3:0] ST_NOP_DONE = 4'd8;

`ifdef GPR_TRANSFER_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  // Everything the controller drives toward the register file, bus and decoder.
  typedef struct packed {
    logic [SEL_W-1:0] regsel;
    logic             rin;
    logic             rout;
    logic [TMP_W-1:0] tmpin;
    logic [TMP_W-1:0] tmpout;
    logic             immout;
    logic             busy;
    logic             done;
    logic             err;
  } ctrl_t;

endpackage

// File: rtl/gpr_transfer_ctrl_if.sv
// Decoder handshake plus register-file/bus control lines of gpr_transfer_ctrl.
interface gpr_transfer_ctrl_if;
  import gpr_ctrl_pkg::*;

  logic [OP_W-1:0]  op;
  logic             start;
  logic [SEL_W-1:0] rs;
  logic [SEL_W-1:0] rd;
  logic [SEL_W-1:0] regSel;
  logic             Rin;
  logic             Rout;
  logic [TMP_W-1:0] tmpIn;
  logic [TMP_W-1:0] tmpOut;
  logic             immOut;
  logic             busy;
  logic             done;
  logic             err;

  // Requester side (instruction decoder / environment).
  modport master (
    output start, op, rs, rd,
    input  regSel, Rin, Rout, tmpIn, tmpOut, immOut, busy, done, err
  );

  // Controller side.
  modport slave (
    input  start, op, rs, rd,
    output regSel, Rin, Rout, tmpIn, tmpOut, immOut, busy, done, err
  );
endinterface

// File: rtl/gpr_transfer_ctrl_outdec.sv
// Control-line decoder: maps a sequencer state and latched operands to bus/register enables.
// SWP state decode is present only when GPR_TRANSFER_SWAP_EN is defined.
module gpr_ctrl_outdec
  import gpr_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [OP_W-1:0]    op,
  input  logic [SEL_W-1:0]   rs,
  input  logic [SEL_W-1:0]   rd,
  output ctrl_t              ctrl_c
);

  always_comb begin
    ctrl_c      = '0;
    ctrl_c.busy = (state != ST_IDLE);
    case (state)
      ST_MOV_RD: begin
        ctrl_c.regsel = rs;
        ctrl_c.rout   = 1'b1;
        ctrl_c.tmpin  = 2'b01;
      end
      ST_MOV_WR: begin
        ctrl_c.regsel = rd;
        ctrl_c.tmpout = 2'b01;
        ctrl_c.rin    = 1'b1;
        ctrl_c.done   = 1'b1;
      end
      ST_LDI_WR: begin
        ctrl_c.regsel = rd;
        ctrl_c.immout = 1'b1;
        ctrl_c.rin    = 1'b1;
        ctrl_c.done   = 1'b1;
      end
`ifdef GPR_TRANSFER_SWAP_EN
      // rs->T0, rd->T1, T1->rs, T0->rd
      ST_SWP_A: begin
        ctrl_c.regsel = rs;
        ctrl_c.rout   = 1'b1;
        ctrl_c.tmpin  = 2'b01;
      end
      ST_SWP_B: begin
        ctrl_c.regsel = rd;
        ctrl_c.rout   = 1'b1;
        ctrl_c.tmpin  = 2'b10;
      end
      ST_SWP_C: begin
        ctrl_c.regsel = rs;
        ctrl_c.tmpout = 2'b10;
        ctrl_c.rin    = 1'b1;
      end
      ST_SWP_D: begin
        ctrl_c.regsel = rd;
        ctrl_c.tmpout = 2'b01;
        ctrl_c.rin    = 1'b1;
        ctrl_c.done   = 1'b1;
      end
`endif
      ST_NOP_DONE: begin
        ctrl_c.done = 1'b1;
        ctrl_c.err  = !SWAP_EN && (op == OP_SWAP);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gpr_transfer_ctrl.sv
// Register-file transfer micro-sequencer: MOV, LDI and (with GPR_TRANSFER_SWAP_EN) SWAP
// over a single shared bus, one transfer per cycle.
module gpr_transfer_ctrl
  import gpr_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  gpr_transfer_ctrl_if.slave  bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [SEL_W-1:0]   rs_q, rs_d;
  logic [SEL_W-1:0]   rd_q, rd_d;
  ctrl_t              ctrl_c, ctrl_q;

  // State, operand latches and outputs; outputs are decoded from the next state so they
  // line up with the state they belong to while still coming straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rs_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_c;
    end
  end

  // Next state; operands are only captured on an accepted start.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d = bus.op;
          rs_d = bus.rs;
          rd_d = bus.rd;
          case (bus.op)
            OP_MOV:  state_d = ST_MOV_RD;
            OP_LDI:  state_d = ST_LDI_WR;
`ifdef GPR_TRANSFER_SWAP_EN
            OP_SWAP: state_d = ST_SWP_A;
`endif
            default: state_d = ST_NOP_DONE;
          endcase
        end
      end
      ST_MOV_RD: state_d = ST_MOV_WR;
`ifdef GPR_TRANSFER_SWAP_EN
      ST_SWP_A:  state_d = ST_SWP_B;
      ST_SWP_B:  state_d = ST_SWP_C;
      ST_SWP_C:  state_d = ST_SWP_D;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  gpr_ctrl_outdec u_outdec (
    .state  (state_d),
    .op     (op_d),
    .rs     (rs_d),
    .rd     (rd_d),
    .ctrl_c (ctrl_c)
  );

  assign bus.regSel = ctrl_q.regsel;
  assign bus.Rin    = ctrl_q.rin;
  assign bus.Rout   = ctrl_q.rout;
  assign bus.tmpIn  = ctrl_q.tmpin;
  assign bus.tmpOut = ctrl_q.tmpout;
  assign bus.immOut = ctrl_q.immout;
  assign bus.busy   = ctrl_q.busy;
  assign bus.done   = ctrl_q.done;
  assign bus.err    = ctrl_q.err;

endmodule

// File: tb/tb_gpr_transfer_ctrl.sv
// Self-checking bench for gpr_transfer_ctrl: register file/bus environment, transfer-level
// reference model, directed table, random ops and multi-cycle corner sequences.
module tb_gpr_transfer_ctrl;
  import gpr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpr_transfer_ctrl_if ifc ();

  gpr_transfer_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Environment: 8x8 register file, temp latches and the shared bus driven by DUT enables
  logic [7:0] rf [8];
  logic [7:0] t0, t1, imm_val, bus_val;
  logic       rf_clr = 1'b1;
  logic       mon_en = 1'b0;

  always_comb begin
    if (ifc.Rout)           bus_val = rf[ifc.regSel];
    else if (ifc.tmpOut[0]) bus_val = t0;
    else if (ifc.tmpOut[1]) bus_val = t1;
    else if (ifc.immOut)    bus_val = imm_val;
    else                    bus_val = 8'h00;
  end

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      t0 <= 8'h00;
      t1 <= 8'h00;
    end else begin
      if (ifc.Rin)      rf[ifc.regSel] <= bus_val;
      if (ifc.tmpIn[0]) t0 <= bus_val;
      if (ifc.tmpIn[1]) t1 <= bus_val;
    end
  end

  // Bus contention and read/write exclusivity, every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if (!$onehot0({ifc.Rout, ifc.tmpOut, ifc.immOut}) || (ifc.Rin && ifc.Rout)) begin
        n_fail++;
        $display("FAIL bus_invariant t=%0t: Rout=%b tmpOut=%b immOut=%b Rin=%b, required one-hot-or-zero drivers and !(Rin&Rout)",
                 $time, ifc.Rout, ifc.tmpOut, ifc.immOut, ifc.Rin);
      end
    end
  end

  // ---------------- reference model (transfer level) ----------------
  localparam logic [2:0] EP_NONE = 3'd0, EP_REG = 3'd1, EP_T0 = 3'd2, EP_T1 = 3'd3, EP_IMM = 3'd4;

  logic [7:0] exp_rf [8];
  ctrl_t      exp_q [$];

  function automatic ctrl_t xfer(input logic [2:0] src, input logic [2:0] sreg,
                                 input logic [2:0] dst, input logic [2:0] dreg,
                                 input bit last, input bit er);
    ctrl_t c;
    c = '0;
    c.busy = 1'b1;
    c.done = last;
    c.err  = er;
    case (src)
      EP_REG: begin c.regsel = sreg; c.rout = 1'b1; end
      EP_T0:  c.tmpout = 2'b01;
      EP_T1:  c.tmpout = 2'b10;
      EP_IMM: c.immout = 1'b1;
      default: ;
    endcase
    case (dst)
      EP_REG: begin c.regsel = dreg; c.rin = 1'b1; end
      EP_T0:  c.tmpin = 2'b01;
      EP_T1:  c.tmpin = 2'b10;
      default: ;
    endcase
    return c;
  endfunction

  task automatic model_op(input logic [1:0] op, input logic [2:0] rs, input logic [2:0] rd,
                          input logic [7:0] imm);
    logic [7:0] a, b;
    case (op)
      2'b01: begin
        exp_q.push_back(xfer(EP_REG, rs, EP_T0, 3'd0, 1'b0, 1'b0));
        exp_q.push_back(xfer(EP_T0, 3'd0, EP_REG, rd, 1'b1, 1'b0));
        exp_rf[rd] = exp_rf[rs];
      end
      2'b10: begin
        exp_q.push_back(xfer(EP_IMM, 3'd0, EP_REG, rd, 1'b1, 1'b0));
        exp_rf[rd] = imm;
      end
      2'b11: begin
        if (SWAP_EN) begin
          exp_q.push_back(xfer(EP_REG, rs, EP_T0, 3'd0, 1'b0, 1'b0));
          exp_q.push_back(xfer(EP_REG, rd, EP_T1, 3'd0, 1'b0, 1'b0));
          exp_q.push_back(xfer(EP_T1, 3'd0, EP_REG, rs, 1'b0, 1'b0));
          exp_q.push_back(xfer(EP_T0, 3'd0, EP_REG, rd, 1'b1, 1'b0));
          a = exp_rf[rs];
          b = exp_rf[rd];
          exp_rf[rs] = b;
          exp_rf[rd] = a;
        end else begin
          exp_q.push_back(xfer(EP_NONE, 3'd0, EP_NONE, 3'd0, 1'b1, 1'b1));
        end
      end
      default: exp_q.push_back(xfer(EP_NONE, 3'd0, EP_NONE, 3'd0, 1'b1, 1'b0));
    endcase
  endtask

  // ---------------- check helpers ----------------
  function automatic ctrl_t sample();
    ctrl_t c;
    c.regsel = ifc.regSel;
    c.rin    = ifc.Rin;
    c.rout   = ifc.Rout;
    c.tmpin  = ifc.tmpIn;
    c.tmpout = ifc.tmpOut;
    c.immout = ifc.immOut;
    c.busy   = ifc.busy;
    c.done   = ifc.done;
    c.err    = ifc.err;
    return c;
  endfunction

  task automatic check_ctrl(input string name, input ctrl_t act, input ctrl_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got regSel=%0d Rin=%b Rout=%b tmpIn=%b tmpOut=%b imm=%b busy=%b done=%b err=%b, required regSel=%0d Rin=%b Rout=%b tmpIn=%b tmpOut=%b imm=%b busy=%b done=%b err=%b",
               name, act.regsel, act.rin, act.rout, act.tmpin, act.tmpout, act.immout, act.busy, act.done, act.err,
               exp.regsel, exp.rin, exp.rout, exp.tmpin, exp.tmpout, exp.immout, exp.busy, exp.done, exp.err);
    end
  endtask

  task automatic check_regs(input string name);
    int bad;
    bad = -1;
    for (int i = 7; i >= 0; i--) if (rf[i] !== exp_rf[i]) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: R%0d got %h, required %h", name, bad, rf[bad], exp_rf[bad]);
    end
  endtask

  task automatic check_val(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one op, scramble inputs while busy, check every cycle and report latency
  task automatic run_op(input logic [1:0] op, input logic [2:0] rs, input logic [2:0] rd,
                        input logic [7:0] imm, input string tag, output int unsigned lat);
    int n;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.op    = op;
    ifc.rs    = rs;
    ifc.rd    = rd;
    imm_val   = imm;
    exp_q.delete();
    model_op(op, rs, rd, imm);
    n   = exp_q.size();
    lat = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      ifc.start = 1'($urandom);
      ifc.op    = 2'($urandom);
      ifc.rs    = 3'($urandom);
      ifc.rd    = 3'($urandom);
      @(negedge clk);
      if (ifc.done === 1'b1 && lat == 0) lat = i + 1;
      check_ctrl($sformatf("%s step%0d", tag, i + 1), sample(), exp_q[i]);
    end
    ifc.start = 1'b0;
    @(negedge clk);
    check_ctrl($sformatf("%s idle_after", tag), sample(), '0);
    check_regs($sformatf("%s regs", tag));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rd;
    logic [7:0]  imm;
    int unsigned lat;
    logic [7:0]  val;
  } vec_t;

  vec_t vt [11];

  initial begin
    int unsigned lat;
    ctrl_t       c;

    vt[0]  = '{2'b10, 3'd0, 3'd3, 8'hA5, 1, 8'hA5};
    vt[1]  = '{2'b10, 3'd0, 3'd1, 8'h11, 1, 8'h11};
    vt[2]  = '{2'b10, 3'd0, 3'd2, 8'h22, 1, 8'h22};
    vt[3]  = '{2'b01, 3'd3, 3'd5, 8'h00, 2, 8'hA5};
    vt[4]  = '{2'b10, 3'd0, 3'd7, 8'h3C, 1, 8'h3C};
    vt[5]  = '{2'b11, 3'd1, 3'd2, 8'h00, SWAP_EN ? 4 : 1, SWAP_EN ? 8'h11 : 8'h22};
    vt[6]  = '{2'b00, 3'd0, 3'd5, 8'hFF, 1, 8'hA5};
    vt[7]  = '{2'b01, 3'd4, 3'd4, 8'h00, 2, 8'h00};
    vt[8]  = '{2'b10, 3'd0, 3'd6, 8'h5A, 1, 8'h5A};
    vt[9]  = '{2'b11, 3'd6, 3'd6, 8'h00, SWAP_EN ? 4 : 1, 8'h5A};
    vt[10] = '{2'b01, 3'd0, 3'd3, 8'h00, 2, 8'h00};

    ifc.start = 1'b0;
    ifc.op    = 2'b00;
    ifc.rs    = 3'd0;
    ifc.rd    = 3'd0;
    imm_val   = 8'h00;
    for (int i = 0; i < 8; i++) exp_rf[i] = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_ctrl("reset_state", sample(), '0);
    rst    = 1'b0;
    rf_clr = 1'b0;
    mon_en = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_op(vt[i].op, vt[i].rs, vt[i].rd, vt[i].imm, $sformatf("vec%0d", i), lat);
      check_val($sformatf("vec%0d latency", i), lat, vt[i].lat);
      check_val($sformatf("vec%0d rd_value", i), 32'(rf[vt[i].rd]), 32'(vt[i].val));
    end
    check_val("swap R1", 32'(rf[1]), SWAP_EN ? 32'h22 : 32'h11);

    // start held high with MOV: accepts every third edge, done on the second cycle of each
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.op    = 2'b01;
    ifc.rs    = 3'd7;
    ifc.rd    = 3'd0;
    exp_rf[0] = exp_rf[7];
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      case (k % 3)
        0:       c = xfer(EP_REG, 3'd7, EP_T0, 3'd0, 1'b0, 1'b0);
        1:       c = xfer(EP_T0, 3'd0, EP_REG, 3'd0, 1'b1, 1'b0);
        default: c = '0;
      endcase
      check_ctrl($sformatf("b2b cycle%0d", k), sample(), c);
    end
    ifc.start = 1'b0;
    @(negedge clk);
    check_regs("b2b regs");

    // rst held two cycles mid-operation: abort, no done, no register change
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.op    = 2'b11;
    ifc.rs    = 3'd1;
    ifc.rd    = 3'd2;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_ctrl("rst_abort cycle1", sample(), '0);
    @(negedge clk);
    check_ctrl("rst_abort cycle2", sample(), '0);
    rst = 1'b0;
    @(negedge clk);
    check_ctrl("rst_abort idle", sample(), '0);
    check_regs("rst_abort regs");

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 8'($urandom),
             $sformatf("rnd%0d", i), lat);
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
